// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver and the planned transmitter.
package uart_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    DATA  = 4'b0100,
    STOP  = 4'b1000
  } rx_state_t;

  localparam int unsigned SAMPLE_LO     = 7;
  localparam int unsigned SAMPLE_MID    = 8;
  localparam int unsigned SAMPLE_HI     = 9;
  localparam int unsigned TICKS_PER_BIT = 16;
  localparam int unsigned LAST_T        = 153;

  function automatic int unsigned baud_cnt_max(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / (baud * TICKS_PER_BIT) - 1;
  endfunction

endpackage

// File: rtl/uart_byte_rx_if.sv
// Serial line plus received-byte status bundle for uart_byte_rx.
interface uart_byte_rx_if;
  logic       Rs232_Rx;
  logic [7:0] Data_Byte;
  logic       Rx_Done;
  logic       Frame_Err;
  logic       Rx_Busy;

  modport master (output Rs232_Rx, input Data_Byte, Rx_Done, Frame_Err, Rx_Busy);
  modport slave  (input Rs232_Rx, output Data_Byte, Rx_Done, Frame_Err, Rx_Busy);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample divider: counts 0..BAUD_CNT_MAX while enabled, tick on the terminal count.
module uart_baud_tick #(
  parameter int unsigned BAUD_CNT_MAX = 324
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (BAUD_CNT_MAX > 0) ? $clog2(BAUD_CNT_MAX + 1) : 1;
  localparam logic [W-1:0] CNT_LAST = W'(BAUD_CNT_MAX);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver, 16x oversampling with 2-of-3 majority vote around mid-bit.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input logic           Clk,
  input logic           Rst,
  uart_byte_rx_if.slave rx_if
);

  localparam int unsigned BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, BAUD);
  localparam int unsigned PH_BITS      = $clog2(TICKS_PER_BIT);
  localparam int unsigned BIT_W        = 8 - PH_BITS;

  localparam logic [PH_BITS-1:0] PH_LO     = PH_BITS'(SAMPLE_LO);
  localparam logic [PH_BITS-1:0] PH_MID    = PH_BITS'(SAMPLE_MID);
  localparam logic [PH_BITS-1:0] PH_HI     = PH_BITS'(SAMPLE_HI);
  localparam logic [BIT_W-1:0]   LAST_DATA = BIT_W'(8);
  localparam logic [7:0]         T_LAST    = 8'(LAST_T);

  rx_state_t state, state_next;

  logic             sync1, sync2, sync_prev, fall;
  logic             tick, tick_q, decide, vote;
  logic [7:0]       t;
  logic [PH_BITS-1:0] phase;
  logic [BIT_W-1:0] bitn;
  logic             s0, s1;
  logic [7:0]       sh, data_q;
  logic             done_q, err_q, busy_q;
  logic             shift_en, load, err_d, busy_d;

  uart_baud_tick #(.BAUD_CNT_MAX(BAUD_CNT_MAX)) u_tick (
    .clk  (Clk),
    .rst  (Rst),
    .en   (state != IDLE),
    .clr  (state == IDLE),
    .tick (tick)
  );

  assign fall  = sync_prev & ~sync2;
  assign phase = t[PH_BITS-1:0];
  assign bitn  = t[7:PH_BITS];
  // Decisions run in the cycle after the tick, when t already holds the new count.
  assign decide = tick_q && (phase == PH_HI);
  assign vote   = (s0 & s1) | (s0 & sync2) | (s1 & sync2);

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (fall) state_next = START;
      START: if (decide) state_next = vote ? IDLE : DATA;
      DATA:  if (decide && bitn == LAST_DATA) state_next = STOP;
      STOP:  if (decide && t == T_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    shift_en = 1'b0;
    load     = 1'b0;
    err_d    = 1'b0;
    busy_d   = (state != IDLE) && (state_next != IDLE);
    unique case (state)
      DATA: shift_en = decide;
      STOP: begin
        load  = decide && (t == T_LAST) && vote;
        err_d = decide && (t == T_LAST) && !vote;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
      tick_q    <= 1'b0;
      t         <= '0;
      s0        <= 1'b1;
      s1        <= 1'b1;
      sh        <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync1     <= rx_if.Rs232_Rx;
      sync2     <= sync1;
      sync_prev <= sync2;
      tick_q    <= tick;
      if (state == IDLE) t <= '0;
      else if (tick)     t <= t + 1'b1;
      if (tick_q && phase == PH_LO)  s0 <= sync2;
      if (tick_q && phase == PH_MID) s1 <= sync2;
      if (shift_en) sh <= {vote, sh[7:1]};
      if (load)     data_q <= sh;
      done_q <= load;
      err_q  <= err_d;
      busy_q <= busy_d;
    end
  end

  assign rx_if.Data_Byte = data_q;
  assign rx_if.Rx_Done   = done_q;
  assign rx_if.Frame_Err = err_q;
  assign rx_if.Rx_Busy   = busy_q;

endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

Serial-to-parallel UART receiver: 8N1 frames, 16× oversampling, 2-of-3 majority vote at mid-bit. Sits directly upstream of the "Hello" string detector. Data_Byte holds the last good byte and Rx_Done marks each new one, so the detector can be fed one character per strobe. Also reports framing errors and a busy flag for the board-level status LEDs.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- BAUD_CNT_MAX (localparam), CLK_FREQ/(BAUD*16)-1: oversample divider terminal count, integer division (324 at the defaults).
- Clk  input  1  system clock; all logic on the rising edge.
- Rst  input  1  reset, synchronous, active-high.
- Rs232_Rx  input  1  asynchronous serial line, idle high.
- Data_Byte  output  8  last correctly framed byte, LSB received first; reset 8'h00.
- Rx_Done  output  1  one-cycle pulse when Data_Byte has just updated; reset 0.
- Frame_Err  output  1  one-cycle pulse when the stop bit sampled low; reset 0.
- Rx_Busy  output  1  high whenever the FSM is not in IDLE; reset 0.

## Operation
- Input path: 2-flop synchronizer on Rs232_Rx, then a third flop for edge detection. All three flops reset to 1, so a reset never produces a false start.
- Start detect: in IDLE, a synchronized 1→0 transition moves the FSM to START. It also clears the divider counter and tick counter T to 0.
- Divider: counts 0..BAUD_CNT_MAX and emits a tick when the count equals BAUD_CNT_MAX, then wraps. It runs only outside IDLE.
- T increments on each tick. The first tick is T=1.
- Bit b (0=start, 1..8=data D0..D7, 9=stop) is sampled on ticks T=16b+7, 16b+8, 16b+9.
  - The bit value is the majority of the 3 samples.
  - The decision is made in the cycle of the T=16b+9 tick.
- FSM states are IDLE, START, DATA and STOP, with these transitions:
  - IDLE→START on the falling edge.
  - START, at the T=9 decision:
    - majority 1 (false start/glitch): go to IDLE, no output pulse.
    - majority 0: go to DATA.
  - DATA: shift each decided bit into the shift register, LSB first. After D7 (T=137) go to STOP.
  - STOP, at T=153:
    - majority 1: load Data_Byte from the shift register, pulse Rx_Done.
    - majority 0: pulse Frame_Err; Data_Byte is unchanged.
    - Either way, return to IDLE in the same cycle.
- Returning at mid-stop lets a back-to-back frame's start edge be caught with 6.5 ticks of margin.
- Break (line held low): produces Frame_Err once. No new frame is accepted until the line returns high and falls again.
- Rx_Done and Frame_Err are mutually exclusive and never asserted in the same cycle.
- Rst in any state, mid-frame included: next cycle is IDLE, all outputs at reset values, shift register cleared, counters 0. A frame that was in progress is discarded silently.
- A falling edge arriving in IDLE during the same cycle as Rst is ignored.

## Timing
- Sync latency: the pin edge is seen by the FSM 3 clocks after it reaches the first flop.
- Registered outputs: Rx_Done, Frame_Err and Data_Byte change 1 clock after the T=153 tick cycle.
  - Total from the pin falling edge: 3 + 153×(BAUD_CNT_MAX+1) + 1 clocks, ±1 clock for input sampling phase.
- Rx_Busy rises 1 clock after the FSM enters START and falls together with the Rx_Done/Frame_Err pulse.
- Throughput: one byte per 10 bit periods, with zero idle between frames.
- Data_Byte stays stable between Rx_Done pulses and is valid in the Rx_Done cycle.

## Structure
- Shared package uart_pkg:
  - state encoding, one-hot 4-bit: IDLE=4'b0001, START=4'b0010, DATA=4'b0100, STOP=4'b1000.
  - constants SAMPLE_LO=7, SAMPLE_MID=8, SAMPLE_HI=9, TICKS_PER_BIT=16, LAST_T=153.
  - a function computing BAUD_CNT_MAX from CLK_FREQ and BAUD.
- Sub-module uart_baud_tick: divider with enable/clear inputs and a tick output, parameterised by BAUD_CNT_MAX. It is reused by the planned transmitter.
- Top: synchronizer, FSM, T counter, majority vote, shift register, output registers.

## Test plan
All scenarios use sim parameters CLK_FREQ=1_600_000, BAUD=10_000, giving BAUD_CNT_MAX=9, 10 clk/tick and 160 clk/bit.
- Single byte 0x48 ('H'), clean → Data_Byte=8'h48; one Rx_Done pulse 3+1530+1 clocks (±1) after the start edge; Frame_Err stays 0.
- Bytes "Hello" (0x48 0x65 0x6C 0x6C 0x6F) back-to-back, no idle → 5 Rx_Done pulses spaced exactly 1600 clocks; bytes in order; Rx_Busy never low longer than 70 clocks.
- Low pulse 40 clocks wide on an idle line → FSM returns to IDLE; no Rx_Done, no Frame_Err; Data_Byte unchanged.
- Byte 0x55 with its stop bit driven low, after a good 0x48 → one Frame_Err pulse, no Rx_Done, Data_Byte stays 8'h48.
- Byte 0xA5 with D3 inverted for 10 clocks around its T=16·4+8 sample → majority rejects the glitch; Data_Byte=8'hA5.
- Rst pulsed for 1 cycle during D4 of 0x3C, then a clean 0x6F → after Rst all outputs 0 and no pulse for the aborted frame; then Data_Byte=8'h6F with one Rx_Done.
